// File: rtl/slink_axi_tgt_sched.sv
// Round-robin scheduler of AXI AW/W/AR requests onto the shared application-to-link path.
// Keeps W bursts atomic and tracks outstanding writes/reads until their completions return.
module slink_axi_tgt_sched #(
    parameter int unsigned WR_MAX_OT = 8,
    parameter int unsigned RD_MAX_OT = 8,
    parameter int unsigned CNT_W     = 8
) (
    input  logic             axi_clk,
    input  logic             axi_reset_n,
    input  logic             enable,
    input  logic             aw_valid,
    output logic             aw_ready,
    input  logic             w_valid,
    input  logic             w_last,
    output logic             w_ready,
    input  logic             ar_valid,
    output logic             ar_ready,
    input  logic             a2l_ready,
    output logic [1:0]       a2l_sel,
    input  logic             b_done,
    input  logic             r_last_done,
    output logic [CNT_W-1:0] wr_ot,
    output logic [CNT_W-1:0] rd_ot,
    output logic [CNT_W-1:0] w_pend,
    output logic             busy,
    output logic             err
);

    typedef enum logic [1:0] {
        SelNone = 2'd0,
        SelAw   = 2'd1,
        SelW    = 2'd2,
        SelAr   = 2'd3
    } sel_e;

    typedef enum logic {
        StIdle,
        StWBurst
    } state_e;

    localparam logic [CNT_W-1:0] WrMax = CNT_W'(WR_MAX_OT);
    localparam logic [CNT_W-1:0] RdMax = CNT_W'(RD_MAX_OT);

    state_e            state_q;
    sel_e              last_grant_q;
    sel_e              grant;
    logic [CNT_W-1:0]  wr_ot_q, rd_ot_q, w_pend_q;
    logic              err_q;
    logic              aw_el, w_el, ar_el;
    logic              aw_acc, w_acc, ar_acc;

    assign aw_el = enable && aw_valid && (wr_ot_q < WrMax) && (w_pend_q < WrMax);
    assign w_el  = enable && w_valid && (w_pend_q != '0);
    assign ar_el = enable && ar_valid && (rd_ot_q < RdMax);

    // Search starts at the source following the last accepted one: AW -> W -> AR -> AW.
    always_comb begin
        grant = SelNone;
        if (state_q == StWBurst) begin
            if (w_valid) grant = SelW;
        end else begin
            case (last_grant_q)
                SelAw: begin
                    if (w_el)       grant = SelW;
                    else if (ar_el) grant = SelAr;
                    else if (aw_el) grant = SelAw;
                end
                SelW: begin
                    if (ar_el)      grant = SelAr;
                    else if (aw_el) grant = SelAw;
                    else if (w_el)  grant = SelW;
                end
                default: begin
                    if (aw_el)      grant = SelAw;
                    else if (w_el)  grant = SelW;
                    else if (ar_el) grant = SelAr;
                end
            endcase
        end
    end

    assign aw_ready = a2l_ready && (grant == SelAw);
    assign w_ready  = a2l_ready && (grant == SelW);
    assign ar_ready = a2l_ready && (grant == SelAr);
    assign a2l_sel  = grant;

    assign aw_acc = aw_valid && aw_ready;
    assign w_acc  = w_valid && w_ready;
    assign ar_acc = ar_valid && ar_ready;

    function automatic logic [CNT_W-1:0] cnt_upd(input logic [CNT_W-1:0] v,
                                                 input logic inc, input logic dec);
        logic [CNT_W-1:0] r;
        r = v;
        if (inc && !dec && v != '1) r = v + 1'b1;
        if (dec && !inc && v != '0) r = v - 1'b1;
        return r;
    endfunction

    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            state_q      <= StIdle;
            last_grant_q <= SelAr;
            wr_ot_q      <= '0;
            rd_ot_q      <= '0;
            w_pend_q     <= '0;
            err_q        <= 1'b0;
        end else begin
            if (aw_acc)      last_grant_q <= SelAw;
            else if (w_acc)  last_grant_q <= SelW;
            else if (ar_acc) last_grant_q <= SelAr;

            case (state_q)
                StIdle:   if (w_acc && !w_last) state_q <= StWBurst;
                StWBurst: if (w_acc && w_last)  state_q <= StIdle;
                default:                        state_q <= StIdle;
            endcase

            wr_ot_q  <= cnt_upd(wr_ot_q, aw_acc, b_done);
            rd_ot_q  <= cnt_upd(rd_ot_q, ar_acc, r_last_done);
            w_pend_q <= cnt_upd(w_pend_q, aw_acc, w_acc && w_last);

            if ((b_done && wr_ot_q == '0) || (r_last_done && rd_ot_q == '0)) err_q <= 1'b1;
        end
    end

    assign wr_ot  = wr_ot_q;
    assign rd_ot  = rd_ot_q;
    assign w_pend = w_pend_q;
    assign err    = err_q;
    assign busy   = (state_q == StWBurst) || (wr_ot_q != '0) || (rd_ot_q != '0)
                    || (w_pend_q != '0);

endmodule

// File: tb/tb_slink_axi_tgt_sched.sv
// Directed vector bench for slink_axi_tgt_sched with both outstanding limits set to 2.
module tb_slink_axi_tgt_sched;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable, aw_valid, w_valid, w_last, ar_valid, a2l_ready, b_done, r_last_done;
    logic       aw_ready, w_ready, ar_ready, busy, err;
    logic [1:0] a2l_sel;
    logic [7:0] wr_ot, rd_ot, w_pend;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    slink_axi_tgt_sched #(
        .WR_MAX_OT(2),
        .RD_MAX_OT(2),
        .CNT_W    (8)
    ) dut (
        .axi_clk    (clk),
        .axi_reset_n(rst_n),
        .enable     (enable),
        .aw_valid   (aw_valid),
        .aw_ready   (aw_ready),
        .w_valid    (w_valid),
        .w_last     (w_last),
        .w_ready    (w_ready),
        .ar_valid   (ar_valid),
        .ar_ready   (ar_ready),
        .a2l_ready  (a2l_ready),
        .a2l_sel    (a2l_sel),
        .b_done     (b_done),
        .r_last_done(r_last_done),
        .wr_ot      (wr_ot),
        .rd_ot      (rd_ot),
        .w_pend     (w_pend),
        .busy       (busy),
        .err        (err)
    );

    typedef struct {
        logic en, awv, wv, wl, arv, rdy, bd, rld;
        logic awr, wr, arr;
        logic [1:0] sel;
        int wo, ro, wp;
        logic bsy, er;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(int en, int awv, int wv, int wl, int arv, int rdy, int bd,
                                int rld, int awr, int wr, int arr, int sel, int wo, int ro,
                                int wp, int bsy, int er);
        vec_t v;
        v.en  = (en != 0);  v.awv = (awv != 0); v.wv  = (wv != 0);  v.wl  = (wl != 0);
        v.arv = (arv != 0); v.rdy = (rdy != 0); v.bd  = (bd != 0);  v.rld = (rld != 0);
        v.awr = (awr != 0); v.wr  = (wr != 0);  v.arr = (arr != 0);
        v.sel = 2'(sel);
        v.wo  = wo; v.ro = ro; v.wp = wp;
        v.bsy = (bsy != 0); v.er = (er != 0);
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %0d, expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        enable = v.en; aw_valid = v.awv; w_valid = v.wv; w_last = v.wl;
        ar_valid = v.arv; a2l_ready = v.rdy; b_done = v.bd; r_last_done = v.rld;
    endtask

    task automatic check(input vec_t v, input int idx);
        chk("aw_ready", idx, int'(aw_ready), int'(v.awr));
        chk("w_ready",  idx, int'(w_ready),  int'(v.wr));
        chk("ar_ready", idx, int'(ar_ready), int'(v.arr));
        chk("a2l_sel",  idx, int'(a2l_sel),  int'(v.sel));
        chk("wr_ot",    idx, int'(wr_ot),    v.wo);
        chk("rd_ot",    idx, int'(rd_ot),    v.ro);
        chk("w_pend",   idx, int'(w_pend),   v.wp);
        chk("busy",     idx, int'(busy),     int'(v.bsy));
        chk("err",      idx, int'(err),      int'(v.er));
    endtask

    initial begin
        //           en awv wv wl arv rdy bd rld | awr wr arr sel wo ro wp busy err
        // Round robin with everything valid: AW, W, AR, AW.
        vecs.push_back(mk(1,1,1,1,1,1,0,0, 1,0,0,1, 0,0,0,0,0));
        vecs.push_back(mk(1,1,1,1,1,1,0,0, 0,1,0,2, 1,0,1,1,0));
        vecs.push_back(mk(1,1,1,1,1,1,0,0, 0,0,1,3, 1,0,0,1,0));
        vecs.push_back(mk(1,1,1,1,1,1,0,0, 1,0,0,1, 1,1,0,1,0));
        vecs.push_back(mk(1,0,0,0,0,1,0,0, 0,0,0,0, 2,1,1,1,0));
        // Write limit reached; b_done frees a slot one cycle later.
        vecs.push_back(mk(1,1,0,0,0,1,0,0, 0,0,0,0, 2,1,1,1,0));
        vecs.push_back(mk(1,1,0,0,0,1,1,0, 0,0,0,0, 2,1,1,1,0));
        vecs.push_back(mk(1,1,0,0,0,1,0,0, 1,0,0,1, 1,1,1,1,0));
        vecs.push_back(mk(1,0,0,0,0,1,0,0, 0,0,0,0, 2,1,2,1,0));
        // 4-beat burst holds off AR, AR follows the last beat.
        vecs.push_back(mk(1,0,1,0,1,1,0,0, 0,1,0,2, 2,1,2,1,0));
        vecs.push_back(mk(1,0,1,0,1,1,0,0, 0,1,0,2, 2,1,2,1,0));
        vecs.push_back(mk(1,0,1,0,1,1,0,0, 0,1,0,2, 2,1,2,1,0));
        vecs.push_back(mk(1,0,1,1,1,1,0,0, 0,1,0,2, 2,1,2,1,0));
        vecs.push_back(mk(1,0,0,0,1,1,0,0, 0,0,1,3, 2,1,1,1,0));
        // W without pending AW is never granted; AR at its limit too.
        vecs.push_back(mk(1,0,1,1,0,1,0,0, 0,1,0,2, 2,2,1,1,0));
        vecs.push_back(mk(1,0,1,1,0,1,0,0, 0,0,0,0, 2,2,0,1,0));
        vecs.push_back(mk(1,0,1,1,1,1,0,0, 0,0,0,0, 2,2,0,1,0));
        vecs.push_back(mk(1,0,1,1,0,1,1,0, 0,0,0,0, 2,2,0,1,0));
        vecs.push_back(mk(1,1,1,1,0,1,0,0, 1,0,0,1, 1,2,0,1,0));
        vecs.push_back(mk(1,0,1,1,0,1,0,0, 0,1,0,2, 2,2,1,1,0));
        // enable dropped mid-burst: burst finishes, then nothing is granted.
        vecs.push_back(mk(1,0,0,0,0,1,1,1, 0,0,0,0, 2,2,0,1,0));
        vecs.push_back(mk(1,1,0,0,0,1,0,0, 1,0,0,1, 1,1,0,1,0));
        vecs.push_back(mk(1,0,1,0,0,1,0,0, 0,1,0,2, 2,1,1,1,0));
        vecs.push_back(mk(0,0,1,0,1,1,0,0, 0,1,0,2, 2,1,1,1,0));
        vecs.push_back(mk(0,0,1,0,1,1,0,0, 0,1,0,2, 2,1,1,1,0));
        vecs.push_back(mk(0,0,1,1,1,1,0,0, 0,1,0,2, 2,1,1,1,0));
        vecs.push_back(mk(0,1,1,1,1,1,0,0, 0,0,0,0, 2,1,0,1,0));
        // b_done with AR accept, then r_last_done with AR accept.
        vecs.push_back(mk(1,0,0,0,1,1,1,0, 0,0,1,3, 2,1,0,1,0));
        vecs.push_back(mk(1,0,0,0,0,1,0,1, 0,0,0,0, 1,2,0,1,0));
        vecs.push_back(mk(1,0,0,0,1,1,0,1, 0,0,1,3, 1,1,0,1,0));
        vecs.push_back(mk(1,0,0,0,0,1,0,0, 0,0,0,0, 1,1,0,1,0));
        // Drain, then an underflowing r_last_done sets err.
        vecs.push_back(mk(1,0,0,0,0,1,1,0, 0,0,0,0, 1,1,0,1,0));
        vecs.push_back(mk(1,0,0,0,0,1,0,1, 0,0,0,0, 0,1,0,1,0));
        vecs.push_back(mk(1,0,0,0,0,1,0,1, 0,0,0,0, 0,0,0,0,0));
        vecs.push_back(mk(1,0,0,0,0,1,0,0, 0,0,0,0, 0,0,0,0,1));
        // a2l_ready low: grant shown but no transfer.
        vecs.push_back(mk(1,1,0,0,0,0,0,0, 0,0,0,1, 0,0,0,0,1));
        vecs.push_back(mk(1,1,0,0,0,1,0,0, 1,0,0,1, 0,0,0,0,1));

        rst_n = 1'b0;
        drive(mk(0,0,0,0,0,0,0,0, 0,0,0,0, 0,0,0,0,0));
        repeat (2) @(posedge clk);
        #1;
        check(mk(0,0,0,0,0,0,0,0, 0,0,0,0, 0,0,0,0,0), -1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
            @(negedge clk);
            check(vecs[i], i);
            @(posedge clk);
            #1;
        end

        // Start a burst after the last AW, then reset asynchronously mid-burst.
        drive(mk(1,0,1,0,0,1,0,0, 0,0,0,0, 0,0,0,0,0));
        @(negedge clk);
        chk("burst_start_w_ready", 0, int'(w_ready), 1);
        chk("burst_start_w_pend",  0, int'(w_pend), 1);
        @(posedge clk);
        #1;
        enable = 1'b0;
        @(negedge clk);
        chk("in_burst_w_ready", 0, int'(w_ready), 1);
        chk("in_burst_busy",    0, int'(busy), 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_w_ready", 0, int'(w_ready), 0);
        chk("async_rst_sel",     0, int'(a2l_sel), 0);
        chk("async_rst_wr_ot",   0, int'(wr_ot), 0);
        chk("async_rst_w_pend",  0, int'(w_pend), 0);
        chk("async_rst_err",     0, int'(err), 0);
        chk("async_rst_busy",    0, int'(busy), 0);
        @(negedge clk);
        rst_n  = 1'b1;
        enable = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_w_ready", 0, int'(w_ready), 0);
        chk("post_rst_busy",    0, int'(busy), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
